fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequences the dual-port instruction ROM in the fetch stage. Each cycle it drives the ROM with the current PC and the second-slot address, which is the predicted target if the branch predictor says taken, else PC+4. It captures up to two valid instructions into a fetch buffer and hands them in order to decode, up to two per cycle. It handles backend redirects (flush plus new PC), back-pressure from decode, and end-of-program (ROM valid low).

## Interface
- `ADDR_WIDTH`, 32, PC / ROM address width
- `DATA_WIDTH`, 32, instruction width
- `FB_DEPTH`, 8, fetch-buffer entries; power of two, ≥4
- `RESET_PC`, 0, PC loaded on reset
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-low reset
- `rom_addr` out ADDR_WIDTH: slot-0 address to ROM
- `rom_predict_taken` out 1: = `bp_taken` while fetching
- `rom_predict_target` out ADDR_WIDTH: slot-1 address to ROM
- `rom_instruction_0`, `rom_instruction_1` in DATA_WIDTH: ROM read data (combinational)
- `rom_valid` in 2: ROM per-slot valid
- `bp_taken` in 1: predictor says the slot-0 instruction at `rom_addr` is taken
- `bp_target` in ADDR_WIDTH: its predicted target
- `redirect_valid` in 1: backend flush request
- `redirect_pc` in ADDR_WIDTH: restart PC
- `dec_ready` in 2: decode accepts slot 0 / slot 1
- `dec_valid` out 2: buffer head entries valid
- `dec_inst_0`, `dec_inst_1` out DATA_WIDTH: head / head+1 instruction
- `dec_pc_0`, `dec_pc_1` out ADDR_WIDTH: their PCs
- `dec_pred_taken` out 2: per-slot "predicted taken" tag (set only on a slot-0 fetch whose `bp_taken`=1)
- `fetch_state` out 2: FSM state encoding (FETCH=0, STALL=1, END=2)

## Operation
- **FSM:**
  - FETCH: fetches when free entries ≥2, counted before this cycle's dequeue; otherwise goes to STALL.
  - STALL: returns to FETCH when free entries ≥2.
  - FETCH with `rom_valid[0]`=0 goes to END.
  - END: holds PC and issues no enqueues until a redirect.
- **Fetch group:**
  - `rom_addr`=pc.
  - `rom_predict_target` = `bp_taken` ? `bp_target` : pc+4.
  - Enqueue slot 0 if `rom_valid[0]`. Enqueue slot 1 only if `rom_valid[0]` and `rom_valid[1]`.
  - Next pc = `rom_predict_target`+4 if both enqueued. If only slot 0 is enqueued, next pc = `rom_predict_target`.
  - The slot-1 instruction's own prediction is not consulted; mispredicts recover through redirect.
- **Redirect** (highest priority):
  - On the cycle `redirect_valid`=1, the buffer is flushed (count←0), pc←`redirect_pc`, state←FETCH.
  - That cycle's ROM data and any dequeue are discarded; `dec_valid` is forced to 0 in that cycle.
- **Dequeue:**
  - `dec_valid[0]`=count≥1; `dec_valid[1]`=count≥2.
  - Slot 1 is consumed only if slot 0 is also consumed.
  - Dequeue count = v0&r0 + (v0&r0&v1&r1).
- **Arithmetic:**
  - PC arithmetic wraps modulo 2^ADDR_WIDTH.
  - Buffer pointers wrap modulo FB_DEPTH.
  - Count is width log2(FB_DEPTH)+1.
- **Simultaneous events:** enqueue and dequeue in the same cycle are legal; count updates by enqueued−dequeued. The buffer never overflows or underflows.
- **Reset values (`rst`=0 at posedge):**
  - pc←RESET_PC, count/pointers←0, state←FETCH.
  - Outputs after reset: `dec_valid`=0, `dec_pred_taken`=0, `fetch_state`=0.
  - Data outputs are undefined while invalid.
  - Reset mid-operation discards all buffered entries.

## Timing
- ROM is combinational: `rom_addr`/`rom_predict_target` are combinational from pc, `bp_*` and state.
- Instructions fetched in cycle N appear on `dec_*` in cycle N+1 when the buffer was empty. Buffer outputs are registered head entries, with no same-cycle bypass.
- Redirect latency: `redirect_valid` in cycle N → ROM addressed with `redirect_pc` in N+1 → first instruction at decode in N+2.
- STALL→FETCH decision uses the registered count, so at most one bubble follows the release of back-pressure.

## Configuration
- `FETCH_PERF_CNT_EN`: when defined, the block adds three 32-bit saturating output counters:
  - `perf_fetched`: instructions enqueued.
  - `perf_stall_cycles`: cycles in STALL.
  - `perf_redirects`: redirect cycles.
- All three counters reset to 0 on `rst`.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

## Test plan
- Straight-line: ROM holds 6 words from address 0, `bp_taken`=0, `dec_ready`=2'b11 → pairs (0,4), (8,12), (16,20) at decode, each arriving the cycle after its fetch. Then `rom_valid[0]`=0 → `fetch_state`=END, `dec_valid`=0.
- Predicted taken: pc=0x8, `bp_taken`=1, `bp_target`=0x40 → `rom_predict_target`=0x40, `dec_pc_1`=0x40, `dec_pred_taken`=2'b01, next pc=0x44.
- Back-pressure: `dec_ready`=0 with FB_DEPTH=8 → 4 fetches fill the buffer, then `fetch_state`=STALL and pc holds. Set `dec_ready`=2'b11 → FETCH resumes and order is preserved.
- Redirect while full and dequeuing: `redirect_valid`=1, `redirect_pc`=0x100 → `dec_valid`=0 that cycle and the following one. Next `dec_pc_0`=0x100, with no stale entries.
- Partial valid: last word at 0x14, pc=0x14 → only slot 0 is enqueued (`dec_valid`=2'b01), then END.
- Reset mid-stream: `rst`=0 for one cycle with 5 buffered entries → `dec_valid`=0, pc=RESET_PC, and perf counters (if enabled) are 0.

Source files
------------

// File: rtl/fetch_controller_if.sv
// fetch_controller_if: ROM, predictor, redirect and decode-side signals
// of the fetch controller; master is the controller, slave its environment.
interface fetch_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_predict_taken;
  logic [ADDR_WIDTH-1:0] rom_predict_target;
  logic [DATA_WIDTH-1:0] rom_instruction_0;
  logic [DATA_WIDTH-1:0] rom_instruction_1;
  logic [1:0]            rom_valid;
  logic                  bp_taken;
  logic [ADDR_WIDTH-1:0] bp_target;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [1:0]            dec_ready;
  logic [1:0]            dec_valid;
  logic [DATA_WIDTH-1:0] dec_inst_0;
  logic [DATA_WIDTH-1:0] dec_inst_1;
  logic [ADDR_WIDTH-1:0] dec_pc_0;
  logic [ADDR_WIDTH-1:0] dec_pc_1;
  logic [1:0]            dec_pred_taken;
  logic [1:0]            fetch_state;

  modport master (
    output rom_addr, rom_predict_taken, rom_predict_target,
    output dec_valid, dec_inst_0, dec_inst_1,
    output dec_pc_0, dec_pc_1, dec_pred_taken, fetch_state,
    input  rom_instruction_0, rom_instruction_1, rom_valid,
    input  bp_taken, bp_target,
    input  redirect_valid, redirect_pc,
    input  dec_ready
  );

  modport slave (
    input  rom_addr, rom_predict_taken, rom_predict_target,
    input  dec_valid, dec_inst_0, dec_inst_1,
    input  dec_pc_0, dec_pc_1, dec_pred_taken, fetch_state,
    output rom_instruction_0, rom_instruction_1, rom_valid,
    output bp_taken, bp_target,
    output redirect_valid, redirect_pc,
    output dec_ready
  );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: two-wide ROM fetch into an in-order fetch buffer.
// Optional saturating perf counters when FETCH_PERF_CNT_EN is defined.
module fetch_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FB_DEPTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst,
  fetch_controller_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects
`endif
);

  localparam int PW = $clog2(FB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_STALL = 2'd1,
    S_END   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_n;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_n;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_n;
  logic [PW-1:0]         r_rd;
  logic [PW-1:0]         r_wr;
  logic [PW-1:0]         w_rd_n;
  logic [PW-1:0]         w_wr_n;
  logic [PW-1:0]         w_rd1;
  logic [PW-1:0]         w_wr1;

  logic [DATA_WIDTH-1:0] r_inst [FB_DEPTH];
  logic [ADDR_WIDTH-1:0] r_pcs  [FB_DEPTH];
  logic [FB_DEPTH-1:0]   r_pred;

  logic                  w_redir;
  logic                  w_room;
  logic                  w_fetch;
  logic [ADDR_WIDTH-1:0] w_tgt;
  logic                  w_enq0;
  logic                  w_enq1;
  logic                  w_v0;
  logic                  w_v1;
  logic                  w_deq0;
  logic                  w_deq1;
  logic [CW-1:0]         w_nenq;
  logic [CW-1:0]         w_ndeq;

  assign w_redir = bus.redirect_valid;
  assign w_rd1   = r_rd + PW'(1);
  assign w_wr1   = r_wr + PW'(1);

  // Room is judged on the registered count, before this cycle's dequeue.
  assign w_room  = (r_cnt <= CW'(FB_DEPTH - 2));
  assign w_fetch = (r_state == S_FETCH) && w_room && !w_redir;

  assign w_tgt = bus.bp_taken ? bus.bp_target
                              : r_pc + ADDR_WIDTH'(4);

  assign w_enq0 = w_fetch && bus.rom_valid[0];
  assign w_enq1 = w_enq0 && bus.rom_valid[1];

  assign w_v0   = (r_cnt != '0) && !w_redir;
  assign w_v1   = (r_cnt >= CW'(2)) && !w_redir;
  assign w_deq0 = w_v0 && bus.dec_ready[0];
  assign w_deq1 = w_deq0 && w_v1 && bus.dec_ready[1];

  assign w_nenq = CW'(w_enq0) + CW'(w_enq1);
  assign w_ndeq = CW'(w_deq0) + CW'(w_deq1);

  assign bus.rom_addr           = r_pc;
  assign bus.rom_predict_target = w_tgt;
  assign bus.rom_predict_taken  = w_fetch && bus.bp_taken;

  assign bus.dec_valid      = {w_v1, w_v0};
  assign bus.dec_inst_0     = r_inst[r_rd];
  assign bus.dec_inst_1     = r_inst[w_rd1];
  assign bus.dec_pc_0       = r_pcs[r_rd];
  assign bus.dec_pc_1       = r_pcs[w_rd1];
  assign bus.dec_pred_taken = {w_v1 && r_pred[w_rd1],
                               w_v0 && r_pred[r_rd]};
  assign bus.fetch_state    = r_state;

  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_cnt_n   = r_cnt + w_nenq - w_ndeq;
    w_rd_n    = r_rd + PW'(w_ndeq);
    w_wr_n    = r_wr + PW'(w_nenq);
    if (w_redir) begin
      w_state_n = S_FETCH;
      w_pc_n    = bus.redirect_pc;
      w_cnt_n   = '0;
      w_rd_n    = '0;
      w_wr_n    = '0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (!w_room) begin
            w_state_n = S_STALL;
          end else if (!bus.rom_valid[0]) begin
            w_state_n = S_END;
          end else if (w_enq1) begin
            w_pc_n = w_tgt + ADDR_WIDTH'(4);
          end else begin
            w_pc_n = w_tgt;
          end
        end
        S_STALL: begin
          if (w_room) w_state_n = S_FETCH;
        end
        S_END: begin
          w_state_n = S_END;
        end
        default: begin
          w_state_n = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_cnt   <= w_cnt_n;
      r_rd    <= w_rd_n;
      r_wr    <= w_wr_n;
    end
  end

  // Payload storage carries no reset; validity lives in r_cnt.
  always_ff @(posedge clk) begin
    if (w_enq0) begin
      r_inst[r_wr] <= bus.rom_instruction_0;
      r_pcs[r_wr]  <= r_pc;
      r_pred[r_wr] <= bus.bp_taken;
    end
    if (w_enq1) begin
      r_inst[w_wr1] <= bus.rom_instruction_1;
      r_pcs[w_wr1]  <= w_tgt;
      r_pred[w_wr1] <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_pf_fetch;
  logic [31:0] r_pf_stall;
  logic [31:0] r_pf_redir;
  logic [32:0] w_pf_sum;

  assign w_pf_sum = {1'b0, r_pf_fetch} + 33'(w_nenq);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pf_fetch <= '0;
      r_pf_stall <= '0;
      r_pf_redir <= '0;
    end else begin
      r_pf_fetch <= w_pf_sum[32] ? '1 : w_pf_sum[31:0];
      if (r_state == S_STALL && r_pf_stall != '1)
        r_pf_stall <= r_pf_stall + 32'd1;
      if (w_redir && r_pf_redir != '1)
        r_pf_redir <= r_pf_redir + 32'd1;
    end
  end

  assign perf_fetched      = r_pf_fetch;
  assign perf_stall_cycles = r_pf_stall;
  assign perf_redirects    = r_pf_redir;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: table-driven and hand-sequenced checks of the
// fetch controller against a ROM model and an in-order scoreboard.
module tb_fetch_controller;

  logic clk;
  logic rst;
  logic [31:0] rom_end;
  int n_chk;
  int n_err;

  fetch_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_redirects;
`endif

  fetch_controller #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .FB_DEPTH(8),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall_cycles(perf_stall_cycles),
    .perf_redirects(perf_redirects)
`endif
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hA5C3_0000 ^ a;
  endfunction

  assign bus.rom_instruction_0 = inst_of(bus.rom_addr);
  assign bus.rom_instruction_1 = inst_of(bus.rom_predict_target);
  assign bus.rom_valid = {bus.rom_predict_target < rom_end,
                          bus.rom_addr < rom_end};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic [1:0]  rdy;
    logic [1:0]  ev;
    logic [31:0] epc0;
    logic [31:0] epc1;
    logic [1:0]  est;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic pred);
    exp_t e;
    e.pc = pc;
    e.pred = pred;
    sbq.push_back(e);
  endtask

  task automatic pop_slot(input int s);
    exp_t e;
    logic [31:0] apc;
    logic [31:0] ain;
    logic ap;
    apc = (s == 0) ? bus.dec_pc_0 : bus.dec_pc_1;
    ain = (s == 0) ? bus.dec_inst_0 : bus.dec_inst_1;
    ap  = bus.dec_pred_taken[s];
    if (sbq.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_empty: slot %0d got pc %0h required none",
               s, apc);
    end else begin
      e = sbq.pop_front();
      chk("sb_pc", 64'(apc), 64'(e.pc));
      chk("sb_inst", 64'(ain), 64'(inst_of(e.pc)));
      chk("sb_pred", 64'(ap), 64'(e.pred));
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.dec_valid[0] === 1'b1 && bus.dec_ready[0] === 1'b1) begin
        pop_slot(0);
        if (bus.dec_valid[1] === 1'b1 && bus.dec_ready[1] === 1'b1)
          pop_slot(1);
      end
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = pc;
    to_neg();
    chk("redir_valid0", 64'(bus.dec_valid), 64'd0);
    to_next();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    rom_end = 32'h18;
    bus.bp_taken = 1'b0;
    bus.bp_target = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.dec_ready = 2'b00;

    vt[0] = '{2'b11, 2'b00, 32'h0,  32'h0,  2'd0, 32'h0};
    vt[1] = '{2'b11, 2'b11, 32'h0,  32'h4,  2'd0, 32'h8};
    vt[2] = '{2'b11, 2'b11, 32'h8,  32'hC,  2'd0, 32'h10};
    vt[3] = '{2'b11, 2'b11, 32'h10, 32'h14, 2'd0, 32'h18};
    vt[4] = '{2'b11, 2'b00, 32'h0,  32'h0,  2'd2, 32'h18};
    vt[5] = '{2'b11, 2'b00, 32'h0,  32'h0,  2'd2, 32'h18};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.dec_valid), 64'd0);
    chk("rst_pred", 64'(bus.dec_pred_taken), 64'd0);
    chk("rst_state", 64'(bus.fetch_state), 64'd0);
    chk("rst_addr", 64'(bus.rom_addr), 64'h0);
    rst = 1'b1;

    // straight-line program, one pair per cycle
    for (int a = 0; a < 6; a++) push(32'(a * 4), 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.dec_ready = vt[i].rdy;
      to_neg();
      chk("t_valid", 64'(bus.dec_valid), 64'(vt[i].ev));
      if (vt[i].ev[0])
        chk("t_pc0", 64'(bus.dec_pc_0), 64'(vt[i].epc0));
      if (vt[i].ev[1])
        chk("t_pc1", 64'(bus.dec_pc_1), 64'(vt[i].epc1));
      chk("t_state", 64'(bus.fetch_state), 64'(vt[i].est));
      chk("t_addr", 64'(bus.rom_addr), 64'(vt[i].eaddr));
      to_next();
    end

    // predicted taken at 0x8 toward 0x40
    rom_end = 32'h200;
    redirect_to(32'h8);
    bus.bp_taken = 1'b1;
    bus.bp_target = 32'h40;
    push(32'h8, 1'b1);
    push(32'h40, 1'b0);
    to_neg();
    chk("bp_addr", 64'(bus.rom_addr), 64'h8);
    chk("bp_tgt", 64'(bus.rom_predict_target), 64'h40);
    chk("bp_taken", 64'(bus.rom_predict_taken), 64'd1);
    to_next();
    bus.bp_taken = 1'b0;
    to_neg();
    chk("bp_valid", 64'(bus.dec_valid), 64'd3);
    chk("bp_pc1", 64'(bus.dec_pc_1), 64'h40);
    chk("bp_pred", 64'(bus.dec_pred_taken), 64'd1);
    chk("bp_next", 64'(bus.rom_addr), 64'h44);
    to_next();

    // back-pressure fills the buffer, then release
    rom_end = 32'h30;
    bus.dec_ready = 2'b00;
    redirect_to(32'h0);
    for (int a = 0; a < 12; a++) push(32'(a * 4), 1'b0);
    repeat (4) begin
      to_neg();
      to_next();
    end
    to_neg();
    chk("bpr_st_f", 64'(bus.fetch_state), 64'd0);
    to_next();
    to_neg();
    chk("bpr_stall", 64'(bus.fetch_state), 64'd1);
    chk("bpr_pc", 64'(bus.rom_addr), 64'h20);
    chk("bpr_valid", 64'(bus.dec_valid), 64'd3);
    chk("bpr_head", 64'(bus.dec_pc_0), 64'h0);
    to_next();
    bus.dec_ready = 2'b11;
    to_neg();
    chk("bpr_hold1", 64'(bus.fetch_state), 64'd1);
    to_next();
    to_neg();
    chk("bpr_hold2", 64'(bus.fetch_state), 64'd1);
    to_next();
    to_neg();
    chk("bpr_resume", 64'(bus.fetch_state), 64'd0);
    chk("bpr_raddr", 64'(bus.rom_addr), 64'h20);
    to_next();
    for (int k = 0; k < 40; k++) begin
      if (sbq.size() == 0) break;
      to_next();
    end
    chk("bpr_drain", 64'(sbq.size()), 64'd0);
    to_neg();
    chk("bpr_end", 64'(bus.fetch_state), 64'd2);
    to_next();

    // redirect while full and dequeuing
    rom_end = 32'h108;
    bus.dec_ready = 2'b00;
    redirect_to(32'h0);
    repeat (6) begin
      to_neg();
      to_next();
    end
    bus.dec_ready = 2'b11;
    redirect_to(32'h100);
    push(32'h100, 1'b0);
    push(32'h104, 1'b0);
    to_neg();
    chk("rf_valid1", 64'(bus.dec_valid), 64'd0);
    chk("rf_state", 64'(bus.fetch_state), 64'd0);
    chk("rf_addr", 64'(bus.rom_addr), 64'h100);
    to_next();
    to_neg();
    chk("rf_valid2", 64'(bus.dec_valid), 64'd3);
    chk("rf_pc0", 64'(bus.dec_pc_0), 64'h100);
    to_next();
    to_neg();
    chk("rf_end", 64'(bus.fetch_state), 64'd2);
    chk("rf_empty", 64'(bus.dec_valid), 64'd0);
    chk("rf_sb", 64'(sbq.size()), 64'd0);
    to_next();

    // partial valid at the last word
    rom_end = 32'h18;
    redirect_to(32'h14);
    push(32'h14, 1'b0);
    to_neg();
    to_next();
    to_neg();
    chk("pv_valid", 64'(bus.dec_valid), 64'd1);
    chk("pv_pc0", 64'(bus.dec_pc_0), 64'h14);
    to_next();
    to_neg();
    chk("pv_end", 64'(bus.fetch_state), 64'd2);
    chk("pv_empty", 64'(bus.dec_valid), 64'd0);
    to_next();

    // reset with five buffered entries
    rom_end = 32'h14;
    bus.dec_ready = 2'b00;
    redirect_to(32'h0);
    repeat (4) begin
      to_neg();
      to_next();
    end
    to_neg();
    chk("mr_pre_v", 64'(bus.dec_valid), 64'd3);
    chk("mr_pre_st", 64'(bus.fetch_state), 64'd2);
    to_next();
    rst = 1'b0;
    to_neg();
    to_next();
    rst = 1'b1;
    rom_end = 32'h8;
    bus.dec_ready = 2'b11;
    push(32'h0, 1'b0);
    push(32'h4, 1'b0);
    to_neg();
    chk("mr_valid", 64'(bus.dec_valid), 64'd0);
    chk("mr_state", 64'(bus.fetch_state), 64'd0);
    chk("mr_pc", 64'(bus.rom_addr), 64'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mr_pf_f", 64'(perf_fetched), 64'd0);
    chk("mr_pf_s", 64'(perf_stall_cycles), 64'd0);
    chk("mr_pf_r", 64'(perf_redirects), 64'd0);
`endif
    to_next();
    to_neg();
    chk("mr_v2", 64'(bus.dec_valid), 64'd3);
    chk("mr_head", 64'(bus.dec_pc_0), 64'h0);
    to_next();
    to_neg();
    chk("mr_end", 64'(bus.fetch_state), 64'd2);
    chk("mr_sb", 64'(sbq.size()), 64'd0);
    to_next();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
